// File: rtl/fpga_input_controller.sv
// Board-to-CPU input front end.
// Debounces the four active-low pushbuttons and turns them into press events.
// The step key drives a CPU clock enable. The digit, clear and commit keys run
// a decimal operand entry that is handed to the CPU over valid/ready.
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   KEY[3:0]      raw pushbuttons, active-low: 0 step, 1 digit, 2 clear, 3 commit
//   SW[9:0]       SW[9] manual-clock mode, SW[3:0] digit value
//   step_en       CPU clock enable
//   entry_value   binary value of the digits entered so far (HEX preview)
//   digit_count   number of digits entered so far
//   entry_error   one-cycle pulse when a digit is rejected
//   entry_valid   committed operand available
//   entry_data    committed operand
//   entry_ready   CPU accepts entry_data
module fpga_input_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MAX_DIGITS      = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  KEY,
  input  logic [9:0]  SW,
  output logic        step_en,
  output logic [19:0] entry_value,
  output logic [2:0]  digit_count,
  output logic        entry_error,
  output logic        entry_valid,
  output logic [19:0] entry_data,
  input  logic        entry_ready
);

  localparam int unsigned NKEYS = 4;
  localparam int unsigned VAL_W = 20;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned MUL_W = 24;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIGITS_MAX = CNT_W'(MAX_DIGITS);

  localparam int unsigned K_STEP   = 0;
  localparam int unsigned K_DIGIT  = 1;
  localparam int unsigned K_CLEAR  = 2;
  localparam int unsigned K_COMMIT = 3;

  typedef enum logic {
    IDLE_ENTRY,
    PENDING
  } state_t;

  logic [NKEYS-1:0] sync1;
  logic [NKEYS-1:0] k_s;
  logic [NKEYS-1:0] db_state;
  logic [NKEYS-1:0] press;
  logic [DB_W-1:0]  db_cnt [NKEYS];

  state_t           state;
  state_t           state_nx;
  logic [VAL_W-1:0] value_nx;
  logic [VAL_W-1:0] data_nx;
  logic [CNT_W-1:0] count_nx;
  logic             error_nx;
  logic             valid_nx;

  logic [MUL_W-1:0] value_x10;
  logic [VAL_W-1:0] value_acc;
  logic             digit_bad;
  logic             unused_sw;

  // Only SW[9] and SW[3:0] are functional.
  assign unused_sw = ^SW[8:4];

  // Synchronize keys, then accept a change only after DEBOUNCE_CYCLES
  // consecutive disagreeing samples; a 1->0 acceptance emits a press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '1;
      k_s      <= '1;
      db_state <= '1;
      press    <= '0;
      for (int i = 0; i < NKEYS; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= KEY;
      k_s   <= sync1;
      press <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        if (k_s[i] == db_state[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]   <= '0;
          db_state[i] <= ~db_state[i];
          press[i]    <= db_state[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Free-running enable, or one pulse per step press in manual-clock mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_en <= 1'b0;
    else        step_en <= SW[9] ? press[K_STEP] : 1'b1;
  end

  // value*10 + digit; digit_count < MAX_DIGITS keeps this inside 20 bits.
  assign value_x10 = (MUL_W'(entry_value) << 3) + (MUL_W'(entry_value) << 1);
  assign value_acc = VAL_W'(value_x10 + MUL_W'(SW[3:0]));
  assign digit_bad = (SW[3:0] > 4'd9) || (digit_count >= DIGITS_MAX);

  // Entry state machine: next state and next register values.
  always_comb begin
    state_nx = state;
    value_nx = entry_value;
    count_nx = digit_count;
    data_nx  = entry_data;
    valid_nx = entry_valid;
    error_nx = 1'b0;
    case (state)
      IDLE_ENTRY: begin
        if (press[K_CLEAR]) begin
          value_nx = '0;
          count_nx = '0;
        end else if (press[K_COMMIT]) begin
          data_nx  = entry_value;
          valid_nx = 1'b1;
          value_nx = '0;
          count_nx = '0;
          state_nx = PENDING;
        end else if (press[K_DIGIT]) begin
          if (digit_bad) begin
            error_nx = 1'b1;
          end else begin
            value_nx = value_acc;
            count_nx = digit_count + CNT_W'(1);
          end
        end
      end
      PENDING: begin
        // Key events are dropped here; only the handshake moves us on.
        if (entry_ready) begin
          valid_nx = 1'b0;
          state_nx = IDLE_ENTRY;
        end
      end
      default: state_nx = IDLE_ENTRY;
    endcase
  end

  // Entry state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE_ENTRY;
      entry_value <= '0;
      digit_count <= '0;
      entry_error <= 1'b0;
      entry_valid <= 1'b0;
      entry_data  <= '0;
    end else begin
      state       <= state_nx;
      entry_value <= value_nx;
      digit_count <= count_nx;
      entry_error <= error_nx;
      entry_valid <= valid_nx;
      entry_data  <= data_nx;
    end
  end

endmodule

// File: tb/tb_fpga_input_controller.sv
// Bench for fpga_input_controller: a behavioural model (sample history,
// plain decimal arithmetic) is compared with the DUT every cycle, plus
// hand-computed literal checks on the scenarios of interest.
module tb_fpga_input_controller;

  localparam int unsigned D    = 4;
  localparam int unsigned MAXD = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  KEY = 4'hF;
  logic [9:0]  SW = 10'd0;
  logic        entry_ready = 1'b0;
  logic        step_en;
  logic [19:0] entry_value;
  logic [2:0]  digit_count;
  logic        entry_error;
  logic        entry_valid;
  logic [19:0] entry_data;

  fpga_input_controller #(
    .DEBOUNCE_CYCLES(D),
    .MAX_DIGITS(MAXD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .KEY(KEY),
    .SW(SW),
    .step_en(step_en),
    .entry_value(entry_value),
    .digit_count(digit_count),
    .entry_error(entry_error),
    .entry_valid(entry_valid),
    .entry_data(entry_data),
    .entry_ready(entry_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;
  int ready_mode = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]   m_s1, m_s2, m_db, m_press;
  logic [D-1:0] hist [4];
  logic [3:0]   pr, np;
  logic         m_step, m_err, m_valid, m_pend;
  int           m_val, m_cnt, m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_db = 4'hF; m_press = 4'h0;
      for (int k = 0; k < 4; k++) hist[k] = '1;
      m_step = 0; m_err = 0; m_valid = 0; m_pend = 0;
      m_val = 0; m_cnt = 0; m_data = 0;
    end else begin
      pr = m_press;
      np = 4'h0;
      // A key state flips once the last D synchronized samples all disagree with it.
      for (int k = 0; k < 4; k++) begin
        hist[k] = {hist[k][D-2:0], m_s2[k]};
        if (hist[k] == {D{~m_db[k]}}) begin
          np[k]   = m_db[k];
          m_db[k] = ~m_db[k];
        end
      end
      m_s2 = m_s1;
      m_s1 = KEY;
      m_press = np;
      m_step = SW[9] ? pr[0] : 1'b1;
      m_err = 0;
      if (m_pend) begin
        if (entry_ready) begin m_pend = 0; m_valid = 0; end
      end else if (pr[2]) begin
        m_val = 0; m_cnt = 0;
      end else if (pr[3]) begin
        m_data = m_val; m_valid = 1; m_pend = 1; m_val = 0; m_cnt = 0;
      end else if (pr[1]) begin
        if (int'(SW[3:0]) > 9 || m_cnt >= MAXD) m_err = 1;
        else begin m_val = m_val * 10 + int'(SW[3:0]); m_cnt = m_cnt + 1; end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    check("step_en", step_en, m_step);
    check("entry_value", entry_value, m_val);
    check("digit_count", digit_count, m_cnt);
    check("entry_error", entry_error, m_err);
    check("entry_valid", entry_valid, m_valid);
    check("entry_data", entry_data, m_data);
    if (entry_error) err_pulses++;
  end

  // entry_ready driver: 0 forced low, 1 forced high, 2 random.
  initial forever begin
    @(negedge clk);
    #1;
    case (ready_mode)
      1:       entry_ready = 1'b1;
      2:       entry_ready = ($urandom_range(0, 3) == 0);
      default: entry_ready = 1'b0;
    endcase
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] mask, input int hold);
    KEY = KEY & ~mask;
    tick(hold);
    KEY = KEY | mask;
    tick(D + 4);
  endtask

  task automatic digit(input int d);
    SW[3:0] = 4'(d);
    press(4'b0010, D + 2);
  endtask

  int pulses, at, e0;

  initial begin
    #2 rst_n = 1'b0;
    tick(2);
    check("rst_step_en", step_en, 0);
    check("rst_entry_value", entry_value, 0);
    check("rst_digit_count", digit_count, 0);
    check("rst_entry_valid", entry_valid, 0);
    check("rst_entry_data", entry_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    check("step_en_first_edge", step_en, 1);
    @(negedge clk);
    SW[9] = 1'b1;
    @(posedge clk); #2;
    check("step_en_manual_off", step_en, 0);
    @(negedge clk);
    tick(2);

    // Held step key: one pulse, visible after edge N+1+D+1.
    KEY[0] = 1'b0;
    pulses = 0; at = -1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      if (step_en) begin pulses++; at = i; end
    end
    @(negedge clk);
    KEY[0] = 1'b1;
    tick(D + 4);
    check("step_pulse_count", pulses, 1);
    check("step_pulse_edge", at, 1 + D + 1);

    // Short glitch: no pulse.
    KEY[0] = 1'b0;
    tick(2);
    KEY[0] = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      if (step_en) pulses++;
    end
    @(negedge clk);
    check("glitch_no_pulse", pulses, 0);

    // Six digits, then a seventh is rejected.
    for (int d = 1; d <= 6; d++) digit(d);
    check("value_123456", entry_value, 123456);
    check("model_123456", m_val, 123456);
    check("count_6", digit_count, 6);
    e0 = err_pulses;
    digit(7);
    check("max_digit_err", err_pulses - e0, 1);
    check("max_digit_value", entry_value, 123456);

    // Non-decimal digit is rejected.
    press(4'b0100, D + 2);
    digit(3);
    e0 = err_pulses;
    digit(10);
    check("hex_digit_err", err_pulses - e0, 1);
    check("hex_digit_value", entry_value, 3);
    check("hex_digit_count", digit_count, 1);

    // Commit 654321 and hold it pending.
    press(4'b0100, D + 2);
    for (int d = 6; d >= 1; d--) digit(d);
    press(4'b1000, D + 2);
    check("commit_valid", entry_valid, 1);
    check("commit_data", entry_data, 654321);
    check("model_commit_data", m_data, 654321);
    check("commit_value_cleared", entry_value, 0);
    e0 = err_pulses;
    digit(9);
    press(4'b0100, D + 2);
    check("pending_valid", entry_valid, 1);
    check("pending_data", entry_data, 654321);
    check("pending_value", entry_value, 0);
    check("pending_no_err", err_pulses - e0, 0);
    ready_mode = 1;
    tick(1);
    ready_mode = 0;
    tick(2);
    check("handshake_valid_low", entry_valid, 0);

    // Clear beats commit in the same cycle.
    digit(8);
    digit(8);
    check("value_88", entry_value, 88);
    press(4'b1100, D + 2);
    check("clear_wins_value", entry_value, 0);
    check("clear_wins_valid", entry_valid, 0);
    check("clear_wins_count", digit_count, 0);

    // Reset while pending drops valid immediately.
    digit(5);
    press(4'b1000, D + 2);
    check("pre_reset_valid", entry_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_valid", entry_valid, 0);
    check("async_reset_data", entry_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // Randomized traffic.
    ready_mode = 2;
    for (int it = 0; it < 80; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        SW[3:0] = 4'($urandom_range(0, 11));
        press(4'b0010, D + $urandom_range(0, 4));
      end else if (r == 5) begin
        press(4'b0100, D + $urandom_range(0, 4));
      end else if (r == 6) begin
        press(4'b1000, D + $urandom_range(0, 4));
      end else if (r == 7) begin
        press(4'(1 << $urandom_range(0, 3)), $urandom_range(1, D - 1));
      end else if (r == 8) begin
        SW[9] = ~SW[9];
        tick($urandom_range(1, 4));
      end else begin
        press(4'($urandom_range(1, 15)), D + $urandom_range(0, 4));
      end
    end
    ready_mode = 0;
    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
